// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - decode-stage constants, field positions and control bundle type
package id_pkg;
   localparam logic [1:0] MODE_DP  = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;

   localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111;

   localparam logic [3:0] EXE_NOP = 4'b0000, EXE_MOV = 4'b0001, EXE_ADD = 4'b0010, EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100, EXE_SBC = 4'b0101, EXE_AND = 4'b0110, EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000, EXE_MVN = 4'b1001;

   localparam int RN_LSB = 16, RD_LSB = 12, RM_LSB = 0, IMM_BIT = 25;
   localparam int S_BIT = 20, OP_LSB = 21, MODE_LSB = 26, COND_LSB = 28;

   typedef struct packed {
      logic [3:0] exe_cmd;
      logic       mem_read;
      logic       mem_write;
      logic       wb_en;
      logic       b;
      logic       s;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);
endpackage

// File: rtl/Condition_Check.sv
// rtl/Condition_Check.sv - ARM condition field evaluation against NZCV
module Condition_Check (
   input  logic [3:0] cond,
   input  logic [3:0] status,
   output logic       pass
);
   logic n, z, c, v;
   assign {n, z, c, v} = status;

   // one pass/fail per condition code; 4'b1111 never executes
   always_comb begin
      pass = 1'b0;
      case (cond)
         4'h0: pass = z;
         4'h1: pass = !z;
         4'h2: pass = c;
         4'h3: pass = !c;
         4'h4: pass = n;
         4'h5: pass = !n;
         4'h6: pass = v;
         4'h7: pass = !v;
         4'h8: pass = c && !z;
         4'h9: pass = !c || z;
         4'hA: pass = (n == v);
         4'hB: pass = (n != v);
         4'hC: pass = !z && (n == v);
         4'hD: pass = z || (n != v);
         4'hE: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/Control_Unit.sv
// rtl/Control_Unit.sv - mode/opcode to execute command and memory/write-back controls
module Control_Unit
   import id_pkg::*;
(
   input  logic [1:0] mode,
   input  logic [3:0] opcode,
   input  logic       s_in,
   output logic [3:0] exe_cmd,
   output logic       mem_read,
   output logic       mem_write,
   output logic       wb_en,
   output logic       b,
   output logic       s_out
);
   // data processing writes back except compares; S bit doubles as the load flag for memory ops
   always_comb begin
      exe_cmd = EXE_NOP; mem_read = 1'b0; mem_write = 1'b0; wb_en = 1'b0; b = 1'b0; s_out = 1'b0;
      case (mode)
         MODE_DP: begin
            s_out = s_in;
            wb_en = 1'b1;
            case (opcode)
               OP_MOV: exe_cmd = EXE_MOV;
               OP_MVN: exe_cmd = EXE_MVN;
               OP_ADD: exe_cmd = EXE_ADD;
               OP_ADC: exe_cmd = EXE_ADC;
               OP_SUB: exe_cmd = EXE_SUB;
               OP_SBC: exe_cmd = EXE_SBC;
               OP_AND: exe_cmd = EXE_AND;
               OP_ORR: exe_cmd = EXE_ORR;
               OP_EOR: exe_cmd = EXE_EOR;
               OP_CMP: begin exe_cmd = EXE_SUB; wb_en = 1'b0; end
               OP_TST: begin exe_cmd = EXE_AND; wb_en = 1'b0; end
               default: wb_en = 1'b0;
            endcase
         end
         MODE_MEM: begin
            exe_cmd   = EXE_ADD;
            mem_read  = s_in;
            mem_write = !s_in;
            wb_en     = s_in;
         end
         MODE_BR: b = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/Register_File.sv
// rtl/Register_File.sv - two-read one-write register file, cleared on reset
module Register_File #(
   parameter  int DATA_W  = 32,
   parameter  int REG_CNT = 16,
   localparam int RA_W    = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RA_W-1:0]   src1,
   input  logic [RA_W-1:0]   src2,
   input  logic              wb_en,
   input  logic [RA_W-1:0]   wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   output logic [DATA_W-1:0] reg1,
   output logic [DATA_W-1:0] reg2
);
   logic [DATA_W-1:0] regs [REG_CNT];

   // write port on the rising edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) regs <= '{default: '0};
      else if (wb_en) regs[wb_dest] <= wb_value;
   end

   assign reg1 = regs[src1];
   assign reg2 = regs[src2];
endmodule

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - per-register in-flight write counters with busy/full flags
module id_scoreboard #(
   parameter  int REG_CNT = 16,
   parameter  int CNT_W   = 2,
   localparam int RA_W    = $clog2(REG_CNT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc_en,
   input  logic [RA_W-1:0]    inc_dest,
   input  logic               wb_en,
   input  logic [RA_W-1:0]    wb_dest,
   input  logic               kill_en,
   input  logic [RA_W-1:0]    kill_dest,
   input  logic               flush_en,
   input  logic [RA_W-1:0]    flush_dest,
   input  logic               rel_en,
   input  logic [RA_W-1:0]    rel_dest,
   output logic [REG_CNT-1:0] busy,
   output logic [REG_CNT-1:0] full
);
   localparam int SW = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]   cnt   [REG_CNT];
   logic [CNT_W-1:0]   cnt_d [REG_CNT];
   logic [REG_CNT-1:0] underflow;
   logic [SW-1:0]      up, down;
   logic               early;

   // merge one increment and up to three retirements; rel_* discounts a same-cycle retire from the flags
   always_comb begin
      cnt_d = cnt; underflow = '0; busy = '0; full = '0;
      up = '0; down = '0; early = 1'b0;
      for (int r = 0; r < REG_CNT; r++) begin
         up   = {2'b00, cnt[r]} + SW'(inc_en && inc_dest == RA_W'(r));
         down = SW'(wb_en && wb_dest == RA_W'(r)) + SW'(kill_en && kill_dest == RA_W'(r))
              + SW'(flush_en && flush_dest == RA_W'(r));
         underflow[r] = down > up;
         cnt_d[r]     = underflow[r] ? '0 : CNT_W'(up - down);
         early        = rel_en && rel_dest == RA_W'(r);
         busy[r]      = early ? (cnt[r] > CNT_W'(1)) : (cnt[r] != '0);
         full[r]      = (cnt[r] == CNT_MAX) && !early;
      end
   end

   // counter state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '{default: '0};
      else      cnt <= cnt_d;
   end

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst) underflow == '0);
endmodule

// File: rtl/id_stage_sb.sv
// rtl/id_stage_sb.sv - decode stage with ID/EXE register and RAW scoreboard; ID_WB_BYPASS_EN enables write-back forwarding
module id_stage_sb
   import id_pkg::*;
#(
   parameter  int DATA_W  = 32,
   parameter  int REG_CNT = 16,
   parameter  int PC_REG  = 15,
   parameter  int CNT_W   = 2,
   localparam int RA_W    = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [3:0]        status,
   input  logic              flush,
   input  logic              wb_en_wb,
   input  logic [RA_W-1:0]   dest_wb,
   input  logic [DATA_W-1:0] value_wb,
   input  logic              kill_en,
   input  logic [RA_W-1:0]   kill_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] reg1,
   output logic [DATA_W-1:0] reg2,
   output logic [DATA_W-1:0] pc_out,
   output logic [3:0]        exe_cmd,
   output logic              mem_read,
   output logic              mem_write,
   output logic              wb_en,
   output logic              b,
   output logic              s,
   output logic              imm,
   output logic [11:0]       shift_operand,
   output logic [23:0]       imm24,
   output logic [RA_W-1:0]   dest
);
   logic [RA_W-1:0]    rn, rd, rm, src2;
   logic [DATA_W-1:0]  rf1, rf2, val1, val2;
   logic [REG_CNT-1:0] busy, full;
   logic [3:0]         cu_cmd;
   logic               cu_mr, cu_mw, cu_wb, cu_b, cu_s;
   logic               cond_pass, rn_used, src2_used, stall, load, rel_en;
   ctrl_t              ctrl_cu, ctrl_d;

   assign rn   = RA_W'(instruction_in[RN_LSB +: 4]);
   assign rd   = RA_W'(instruction_in[RD_LSB +: 4]);
   assign rm   = RA_W'(instruction_in[RM_LSB +: 4]);
   assign src2 = cu_mw ? rd : rm;

   Control_Unit u_cu (
      .mode(instruction_in[MODE_LSB +: 2]), .opcode(instruction_in[OP_LSB +: 4]),
      .s_in(instruction_in[S_BIT]), .exe_cmd(cu_cmd), .mem_read(cu_mr),
      .mem_write(cu_mw), .wb_en(cu_wb), .b(cu_b), .s_out(cu_s)
   );

   Condition_Check u_cc (.cond(instruction_in[COND_LSB +: 4]), .status(status), .pass(cond_pass));

   Register_File #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
      .clk(clk), .rst(rst), .src1(rn), .src2(src2), .wb_en(wb_en_wb),
      .wb_dest(dest_wb), .wb_value(value_wb), .reg1(rf1), .reg2(rf2)
   );

`ifdef ID_WB_BYPASS_EN
   assign rel_en = wb_en_wb;
`else
   assign rel_en = 1'b0;
`endif

   id_scoreboard #(.REG_CNT(REG_CNT), .CNT_W(CNT_W)) u_sb (
      .clk(clk), .rst(rst),
      .inc_en(load && cu_wb && cond_pass), .inc_dest(rd),
      .wb_en(wb_en_wb), .wb_dest(dest_wb),
      .kill_en(kill_en), .kill_dest(kill_dest),
      .flush_en(flush && out_valid && wb_en && !out_ready), .flush_dest(dest),
      .rel_en(rel_en), .rel_dest(dest_wb),
      .busy(busy), .full(full)
   );

   assign ctrl_cu   = '{exe_cmd: cu_cmd, mem_read: cu_mr, mem_write: cu_mw, wb_en: cu_wb, b: cu_b, s: cu_s};
   assign ctrl_d    = cond_pass ? ctrl_cu : ctrl_t'({CTRL_W{1'b0}});
   assign rn_used   = !cu_b;
   assign src2_used = !instruction_in[IMM_BIT] || cu_mw;
   assign stall     = (rn_used && busy[rn]) || (src2_used && busy[src2]) || (cu_wb && cond_pass && full[rd]);
   assign in_ready  = !stall && !flush && (!out_valid || out_ready);
   assign load      = in_valid && in_ready;

   // operand select: PC register reads the instruction's PC, same-cycle write-back forwarded in bypass builds
   always_comb begin
      val1 = rf1;
      val2 = rf2;
`ifdef ID_WB_BYPASS_EN
      if (wb_en_wb && dest_wb == rn)   val1 = value_wb;
      if (wb_en_wb && dest_wb == src2) val2 = value_wb;
`endif
      if (rn == RA_W'(PC_REG))   val1 = pc_in;
      if (src2 == RA_W'(PC_REG)) val2 = pc_in;
   end

   // ID/EXE holding register: load on handshake, drop on consume or flush, hold otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0; reg1 <= '0; reg2 <= '0; pc_out <= '0;
         exe_cmd <= '0; mem_read <= 1'b0; mem_write <= 1'b0; wb_en <= 1'b0; b <= 1'b0; s <= 1'b0;
         imm <= 1'b0; shift_operand <= '0; imm24 <= '0; dest <= '0;
      end else if (load) begin
         out_valid     <= 1'b1;
         reg1          <= val1;
         reg2          <= val2;
         pc_out        <= pc_in;
         exe_cmd       <= ctrl_d.exe_cmd;
         mem_read      <= ctrl_d.mem_read;
         mem_write     <= ctrl_d.mem_write;
         wb_en         <= ctrl_d.wb_en;
         b             <= ctrl_d.b;
         s             <= ctrl_d.s;
         imm           <= instruction_in[IMM_BIT];
         shift_operand <= instruction_in[11:0];
         imm24         <= instruction_in[23:0];
         dest          <= rd;
      end else if (flush || out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_id_stage_sb.sv
// tb/tb_id_stage_sb.sv - scoreboard bench for id_stage_sb with directed instruction vectors
module tb_id_stage_sb;
   typedef struct packed {
      logic [31:0] r1, r2, pc;
      logic [3:0]  cmd;
      logic        mr, mw, wb, b, s, imm;
      logic [11:0] sh;
      logic [23:0] i24;
      logic [3:0]  dst;
   } bun_t;

   localparam logic [3:0] AL = 4'hE, EQC = 4'h0;
   localparam logic [3:0] OP_ADD = 4'b0100, OP_SUB = 4'b0010, OP_MOV = 4'b1101;
   localparam logic [3:0] C_NOP = 4'd0, C_MOV = 4'd1, C_ADD = 4'd2, C_SUB = 4'd4;
   localparam logic [4:0] CTL_WB = 5'b00100, CTL_NONE = 5'b00000;

   logic        clk = 1'b0, rst = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] instruction_in = '0, pc_in = '0;
   logic [3:0]  status = '0;
   logic        flush = 1'b0, wb_en_wb = 1'b0, kill_en = 1'b0, out_ready = 1'b1;
   logic [3:0]  dest_wb = '0, kill_dest = '0;
   logic [31:0] value_wb = '0;
   logic        out_valid, mem_read, mem_write, wb_en, b, s, imm;
   logic [31:0] reg1, reg2, pc_out;
   logic [3:0]  exe_cmd, dest;
   logic [11:0] shift_operand;
   logic [23:0] imm24;

   int   checks = 0, errors = 0;
   bun_t expq[$];
   bun_t e_m, a_m;
   bun_t e;

   id_stage_sb dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instruction_in(instruction_in), .pc_in(pc_in), .status(status), .flush(flush),
      .wb_en_wb(wb_en_wb), .dest_wb(dest_wb), .value_wb(value_wb),
      .kill_en(kill_en), .kill_dest(kill_dest), .out_valid(out_valid), .out_ready(out_ready),
      .reg1(reg1), .reg2(reg2), .pc_out(pc_out), .exe_cmd(exe_cmd), .mem_read(mem_read),
      .mem_write(mem_write), .wb_en(wb_en), .b(b), .s(s), .imm(imm),
      .shift_operand(shift_operand), .imm24(imm24), .dest(dest)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dp(input logic [3:0] c, input logic i, input logic [3:0] op,
                                      input logic [3:0] rn_, input logic [3:0] rd_, input logic [11:0] sh);
      return {c, 2'b00, i, op, 1'b0, rn_, rd_, sh};
   endfunction

   function automatic logic [31:0] mem(input logic l, input logic [3:0] rn_, input logic [3:0] rd_,
                                       input logic [11:0] off);
      return {AL, 2'b01, 1'b1, 4'b0100, l, rn_, rd_, off};
   endfunction

   function automatic bun_t mk(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] pc, input logic [3:0] cmd, input logic [4:0] ctl);
      bun_t x;
      x.r1 = r1; x.r2 = r2; x.pc = pc; x.cmd = cmd;
      {x.mr, x.mw, x.wb, x.b, x.s} = ctl;
      x.imm = ins[25]; x.sh = ins[11:0]; x.i24 = ins[23:0]; x.dst = ins[15:12];
      return x;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic issue(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                        input bun_t ex, input int max_wait);
      logic ok;
      ok = 1'b0;
      instruction_in = ins; pc_in = pc; in_valid = 1'b1;
      for (int k = 0; k <= max_wait && !ok; k++) begin
         #2;
         if (in_ready) begin ok = 1'b1; expq.push_back(ex); end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_accept actual=stalled required=accepted", nm);
      end
   endtask

   task automatic wb(input logic [3:0] d, input logic [31:0] v);
      wb_en_wb = 1'b1; dest_wb = d; value_wb = v;
      tick();
      wb_en_wb = 1'b0;
   endtask

   // monitor: every consumed bundle is compared against the oldest expectation
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL bundle_unexpected actual_dest=%0d required=none", dest);
         end else begin
            e_m = expq.pop_front();
            a_m = '{r1: reg1, r2: reg2, pc: pc_out, cmd: exe_cmd, mr: mem_read, mw: mem_write,
                    wb: wb_en, b: b, s: s, imm: imm, sh: shift_operand, i24: imm24, dst: dest};
            if (a_m !== e_m) begin
               errors++;
               $display("FAIL bundle actual=%0h required=%0h", a_m, e_m);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ins;
      repeat (2) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_reg1", reg1, 0);
      chk("rst_dest", dest, 0);
      chk("rst_exe_cmd", exe_cmd, 0);
      chk("rst_wb_en", wb_en, 0);
      rst = 1'b1;
      tick();

      // preload R2=5, R3=7 through issued writers and their write-backs
      ins = dp(AL, 1, OP_MOV, 0, 2, 12'h050);
      issue("mov_r2", ins, 32'h100, mk(ins, 0, 0, 32'h100, C_MOV, CTL_WB), 0);
      ins = dp(AL, 1, OP_MOV, 0, 3, 12'h070);
      issue("mov_r3", ins, 32'h104, mk(ins, 0, 0, 32'h104, C_MOV, CTL_WB), 0);
      wb(2, 5);
      wb(3, 7);

      // ADD R1,R2,R3
      ins = dp(AL, 0, OP_ADD, 2, 1, 12'h003);
      issue("add_r1", ins, 32'h108, mk(ins, 5, 7, 32'h108, C_ADD, CTL_WB), 0);

      // SUB R4,R1,R0 waits for R1 write-back
      ins = dp(AL, 0, OP_SUB, 1, 4, 12'h000);
      e = mk(ins, 12, 0, 32'h10C, C_SUB, CTL_WB);
      instruction_in = ins; pc_in = 32'h10C; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin #2; chk("raw_stall", in_ready, 0); tick(); end
      wb_en_wb = 1'b1; dest_wb = 1; value_wb = 12;
      #2;
`ifdef ID_WB_BYPASS_EN
      chk("raw_release_wb_cycle", in_ready, 1);
      expq.push_back(e);
      tick();
      wb_en_wb = 1'b0;
`else
      chk("raw_stall_wb_cycle", in_ready, 0);
      tick();
      wb_en_wb = 1'b0;
      #2;
      chk("raw_release_after_wb", in_ready, 1);
      expq.push_back(e);
      tick();
`endif
      in_valid = 1'b0;
      wb(4, 12);

      // failed condition: bundle valid but no controls and no scoreboard entry
      ins = dp(EQC, 1, OP_MOV, 0, 6, 12'h090);
      issue("cond_fail", ins, 32'h110, mk(ins, 0, 0, 32'h110, C_NOP, CTL_NONE), 0);
      ins = dp(AL, 0, OP_ADD, 6, 8, 12'h006);
      issue("after_cond_fail", ins, 32'h114, mk(ins, 0, 0, 32'h114, C_ADD, CTL_WB), 0);
      wb(8, 0);

      // held STR flushed: no count change on R9
      out_ready = 1'b0;
      instruction_in = mem(0, 0, 9, 12'h004); pc_in = 32'h118; in_valid = 1'b1;
      #2; chk("str_accept", in_ready, 1);
      tick(); in_valid = 1'b0;
      #2; chk("str_valid", out_valid, 1); chk("str_mem_write", mem_write, 1);
      tick();
      chk("str_hold_valid", out_valid, 1); chk("str_hold_dest", dest, 9);
      flush = 1'b1;
      #2; chk("flush_blocks_load", in_ready, 0);
      tick(); flush = 1'b0;
      #2; chk("str_flushed", out_valid, 0);
      out_ready = 1'b1;
      ins = dp(AL, 0, OP_ADD, 9, 10, 12'h009);
      issue("read_r9", ins, 32'h11C, mk(ins, 0, 0, 32'h11C, C_ADD, CTL_WB), 0);
      wb(10, 0);

      // held LDR R2 flushed: entry for R2 retired by the flush
      out_ready = 1'b0;
      instruction_in = mem(1, 0, 2, 12'h008); pc_in = 32'h120; in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      chk("ldr_hold_wb", wb_en, 1);
      flush = 1'b1;
      tick(); flush = 1'b0;
      #2; chk("ldr_flushed", out_valid, 0);
      out_ready = 1'b1;
      ins = dp(AL, 0, OP_ADD, 2, 11, 12'h000);
      issue("read_r2", ins, 32'h124, mk(ins, 5, 0, 32'h124, C_ADD, CTL_WB), 0);
      wb(11, 5);

      // kill releases a stalled reader of R5
      ins = dp(AL, 1, OP_MOV, 0, 5, 12'h010);
      issue("mov_r5", ins, 32'h128, mk(ins, 0, 0, 32'h128, C_MOV, CTL_WB), 0);
      ins = dp(AL, 0, OP_SUB, 5, 12, 12'h000);
      instruction_in = ins; pc_in = 32'h12C; in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin #2; chk("r5_stall", in_ready, 0); tick(); end
      kill_en = 1'b1; kill_dest = 5;
      #2; chk("r5_stall_kill_cycle", in_ready, 0);
      tick(); kill_en = 1'b0;
      #2; chk("r5_release", in_ready, 1);
      expq.push_back(mk(ins, 0, 0, 32'h12C, C_SUB, CTL_WB));
      tick(); in_valid = 1'b0;
      wb(12, 0);

      // three writers to R7 fill the counter
      for (int k = 1; k <= 3; k++) begin
         ins = dp(AL, 1, OP_MOV, 0, 7, 12'(k * 16));
         issue("mov_r7", ins, 32'h130 + 32'(k), mk(ins, 0, 0, 32'h130 + 32'(k), C_MOV, CTL_WB), 0);
      end
      ins = dp(AL, 1, OP_MOV, 0, 7, 12'h040);
      instruction_in = ins; pc_in = 32'h134; in_valid = 1'b1;
      #2; chk("r7_full_stall", in_ready, 0);
      tick(); in_valid = 1'b0;
      wb(7, 32'h11);
      in_valid = 1'b1; wb_en_wb = 1'b1; dest_wb = 7; value_wb = 32'h22;
      #2; chk("r7_load_with_wb", in_ready, 1);
      expq.push_back(mk(ins, 0, 0, 32'h134, C_MOV, CTL_WB));
      tick(); in_valid = 1'b0; wb_en_wb = 1'b0;
      ins = dp(AL, 1, OP_MOV, 0, 7, 12'h050);
      issue("r7_third_again", ins, 32'h135, mk(ins, 0, 0, 32'h135, C_MOV, CTL_WB), 0);
      ins = dp(AL, 1, OP_MOV, 0, 7, 12'h060);
      instruction_in = ins; pc_in = 32'h136; in_valid = 1'b1;
      #2; chk("r7_full_again", in_ready, 0);
      tick(); in_valid = 1'b0;
      wb(7, 1); wb(7, 2); wb(7, 3);
      issue("r7_after_drain", ins, 32'h136, mk(ins, 0, 0, 32'h136, C_MOV, CTL_WB), 0);
      wb(7, 4);

      repeat (3) tick();
      chk("queue_drained", 64'(expq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_stage_sb.md
# id_stage_sb

Parametrised ARM decode stage with a built-in ID/EXE holding register, valid/ready handshake and a per-register in-flight scoreboard. It replaces the external hazard-unit stall with a local read-after-write interlock. It sits between the IF/ID register and the EXE stage. It reads the register file, decodes control through the existing Control_Unit and Condition_Check modules, and presents a registered instruction bundle to EXE.

## Interface
- DATA_W, 32, datapath width of register values and PC
- REG_CNT, 16, architectural registers; address width RA_W = clog2(REG_CNT)
- PC_REG, 15, register index whose read returns pc_in
- CNT_W, 2, width of each scoreboard counter; max in-flight writes per register = 2^CNT_W-1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction_in/pc_in valid
- in_ready  out  1  stage accepts this cycle
- instruction_in  in  32  ARM instruction word
- pc_in  in  DATA_W  PC of the instruction
- status  in  4  NZCV flags from EXE, sampled at decode
- flush  in  1  squash the held output instruction (taken branch)
- wb_en_wb, dest_wb, value_wb  in  1/RA_W/DATA_W  register-file write; also retires one scoreboard entry
- kill_en, kill_dest  in  1/RA_W  downstream squashed writer; retires one entry without writing
- out_valid  out  1  bundle valid
- out_ready  in  1  EXE consumes the bundle
- reg1, reg2, pc_out  out  DATA_W  operand values and PC
- exe_cmd  out  4; mem_read, mem_write, wb_en, b, s, imm  out  1 each
- shift_operand  out  12; imm24  out  24; dest  out  RA_W

## Operation
- Fields: Rn=[19:16], Rd=[15:12], Rm=[3:0], imm=[25], s=[20], op=[24:21], mode=[27:26], cond=[31:28].
- src2 = Rd when mem_write, else Rm. Reading PC_REG returns pc_in.
- Uses: Rn is used when !b. src2 is used when (!imm | mem_write).
- stall = any used source has a nonzero count, or (wb_en && cond_pass && count[Rd] at max).
- in_ready = !stall && (!out_valid || out_ready). Load happens on in_valid && in_ready.
- cond_pass false: the bundle still loads with out_valid=1. All control bits (exe_cmd, mem_read, mem_write, wb_en, b, s) are 0. No scoreboard increment.
- Scoreboard counter per register, net update each cycle:
  - +1 on a load with wb_en && cond_pass, for Rd.
  - -1 on wb_en_wb, for dest_wb.
  - -1 on kill_en, for kill_dest.
  - -1 on flush while out_valid && held wb_en && !(out_ready), for the held dest.
  - Coincident events on one register sum. Decrement at 0 is ignored and flagged by assertion.
- flush: out_valid is cleared next edge and a same-cycle load is blocked (in_ready=0). If out_ready is also 1, the bundle is treated as consumed and no decrement is made.
- Register file writes on the rising edge when wb_en_wb is set.

## Timing
- Latency: 1 cycle from the load edge to out_valid.
- The bundle holds stable while out_valid && !out_ready.
- Reset: out_valid=0, every bundle output=0, all counters=0, register file cleared to 0. in_ready follows combinationally.
- Back-to-back dependent instructions stall until the producer's write-back or kill retires its entry.
- Reset mid-operation discards the held bundle and all counts.

## Configuration
- ID_WB_BYPASS_EN defined:
  - A same-cycle wb_en_wb to a read address forwards value_wb into reg1/reg2.
  - The matching decrement is counted before the stall check, so the consumer loads in the write-back cycle.
- ID_WB_BYPASS_EN undefined:
  - No forwarding; the consumer loads one cycle after write-back.

## Structure
- Package id_pkg holds:
  - mode and opcode constants
  - exe_cmd encodings
  - field bit positions
  - ctrl bundle width
- Sub-module id_scoreboard holds the REG_CNT counters, the increment/decrement merge, and the busy/full outputs.
- Register_File, Control_Unit and Condition_Check are instantiated unchanged.

## Test plan
- After reset: out_valid=0, in_ready=1. ADD R1,R2,R3 with R2=5, R3=7 preloaded via WB loads, next cycle reg1=5, reg2=7, wb_en=1, dest=1.
- ADD R1 then SUB R4,R1,R0 back to back: in_ready=0 until wb_en_wb dest_wb=1. The SUB then loads in the same cycle with the bypass macro, one cycle later without it.
- cond=EQ with status Z=0: out_valid=1, all control bits 0, and the next instruction reading Rd does not stall.
- Held STR with out_ready=0, then flush=1: out_valid=0 next edge, and count[Rd] stays 0 because a STR does not write back.
- Held LDR R2 with out_ready=0, then flush=1: count[2] returns to 0. A later kill_en=1, kill_dest=5 on a busy R5 releases a stalled reader of R5.
- Three in-flight writers to R7 with CNT_W=2: a fourth writer stalls. Simultaneous load and wb_en_wb on R7 leaves the count unchanged.
